riscv_dmem_resp: RTL and testbench

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

---
 rtl/riscv_dmem_resp.sv | 195 +++++++++++++++++++
 tb/tb_riscv_dmem_resp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for a RISC-V core: one request at a time, handled by an
// IDLE/ACCESS/RESP FSM, with byte/half/word loads and stores and misalignment checks.
module riscv_dmem_resp #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;

  logic [ADDR_W-1:0]   idx;
  logic                acc_err;
  logic [31:0]         cur_word, load_data, st_data, merged_word;
  logic [31:0]         byte_sh, half_sh;
  logic [3:0]          be;
  logic                mem_we;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  // ---------------- request capture ----------------
  always_comb begin
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    if (state_q == IDLE && req_valid) begin
      addr_d   = addr[ADDR_W+1:0];
      funct3_d = funct3;
      wdata_d  = wdata;
      rd_d     = mem_read;
      wr_d     = mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // ---------------- access legality ----------------
  always_comb begin
    acc_err = 1'b0;
    case (funct3_q)
      3'b000, 3'b100: acc_err = 1'b0;
      3'b001, 3'b101: acc_err = addr_q[0];
      3'b010:         acc_err = (addr_q[1:0] != 2'b00);
      default:        acc_err = 1'b1;
    endcase
    if (wr_q && funct3_q[2]) acc_err = 1'b1;
    if (rd_q == wr_q)        acc_err = 1'b1;
  end

  // ---------------- array datapath ----------------
  assign idx = addr_q[ADDR_W+1:2];

  // Words never written since reset read as zero when INIT_ZERO is set.
  always_comb begin
    cur_word = mem_q[idx];
    if (INIT_ZERO && !vld_q[idx]) cur_word = '0;
  end

  always_comb begin
    byte_sh   = cur_word >> {addr_q[1:0], 3'b000};
    half_sh   = cur_word >> {addr_q[1], 4'b0000};
    load_data = cur_word;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_data = {24'b0, byte_sh[7:0]};
      3'b101:  load_data = {16'b0, half_sh[15:0]};
      default: load_data = cur_word;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = wdata_q;
      end
    endcase
    for (int b = 0; b < 4; b++)
      merged_word[8*b +: 8] = be[b] ? st_data[8*b +: 8] : cur_word[8*b +: 8];
  end

  // A reset on the ACCESS edge suppresses the write.
  assign mem_we = (state_q == ACCESS) && wr_q && !acc_err && !rst;

  always_comb begin
    vld_d = vld_q;
    if (mem_we) vld_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merged_word;
  end

  // ---------------- response registers ----------------
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == ACCESS) begin
      err_d   = acc_err;
      rdata_d = (rd_q && !acc_err) ? load_data : 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Directed bench for riscv_dmem_resp: loads/stores, misalignment and illegal
// requests, response back-pressure, aliasing and reset aborts.
module tb_riscv_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, resp_ready, resp_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  riscv_dmem_resp #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .rdata(rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr_req();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
  endtask

  // One full transaction; optionally stalls resp_ready for `hold` cycles.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rdo, output logic erro);
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    clr_req();
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, 32'd2);
    rdo  = rdata;
    erro = resp_err;
    for (int i = 0; i < hold; i++) begin
      // junk request while busy must be ignored
      req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0BAD0BAD;
      @(negedge clk);
      chk({tag, ".hold_data"}, rdata, rdo);
      chk({tag, ".hold_flags"}, {28'b0, resp_valid, resp_err, req_ready, 1'b0},
          {28'b0, 1'b1, erro, 1'b0, 1'b0});
    end
    clr_req();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".handshake"}, {30'b0, req_ready, resp_valid}, 32'b10);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic        e;
    txn(tag, 1'b1, 1'b0, f3, a, 32'b0, 0, d, e);
    chk({tag, ".rdata"}, d, exp_d);
    chk({tag, ".err"}, {31'b0, e}, {31'b0, exp_e});
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic exp_e);
    logic [31:0] d;
    logic        e;
    txn(tag, 1'b0, 1'b1, f3, a, wd, 0, d, e);
    chk({tag, ".rdata"}, d, 32'b0);
    chk({tag, ".err"}, {31'b0, e}, {31'b0, exp_e});
  endtask

  task automatic raw(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] d;
    logic        e;
    txn(tag, rd, wr, f3, a, wd, 0, d, e);
    chk({tag, ".rdata"}, d, 32'b0);
    chk({tag, ".err"}, {31'b0, e}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic        seen;
    rst = 1'b1; resp_ready = 1'b0;
    clr_req();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.outs", {rdata[30:0], resp_err}, 32'b0);
    chk("reset.hs", {30'b0, req_ready, resp_valid}, 32'b10);

    // basic word path
    st("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    ld("lw_10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

    // byte store into lane 1, signed/unsigned reloads
    st("sb_11", 3'b000, 32'h11, 32'h00000080, 1'b0);
    ld("lb_11", 3'b000, 32'h11, 32'hFFFFFF80, 1'b0);
    ld("lbu_11", 3'b100, 32'h11, 32'h00000080, 1'b0);
    ld("lw_10b", 3'b010, 32'h10, 32'hDEAD80EF, 1'b0);

    // misaligned and illegal requests leave the array untouched
    ld("lh_13", 3'b001, 32'h13, 32'b0, 1'b1);
    st("sw_12", 3'b010, 32'h12, 32'h12345678, 1'b1);
    raw("rdwr", 1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111);
    raw("f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'h22222222);
    raw("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h10, 32'h33333333);
    raw("no_op", 1'b0, 1'b0, 3'b010, 32'h10, 32'h44444444);
    raw("sh_11", 1'b0, 1'b1, 3'b001, 32'h11, 32'h55555555);
    ld("lw_10c", 3'b010, 32'h10, 32'hDEAD80EF, 1'b0);

    // halfword lanes
    ld("lh_12", 3'b001, 32'h12, 32'hFFFFDEAD, 1'b0);
    ld("lhu_12", 3'b101, 32'h12, 32'h0000DEAD, 1'b0);
    st("sh_12", 3'b001, 32'h12, 32'hFFFF1234, 1'b0);
    ld("lw_10d", 3'b010, 32'h10, 32'h123480EF, 1'b0);
    ld("lb_13", 3'b000, 32'h13, 32'h00000012, 1'b0);

    // address aliasing and top word
    ld("lw_alias", 3'b010, 32'h00001010, 32'h123480EF, 1'b0);
    st("sw_1ffc", 3'b010, 32'h00001FFC, 32'hCAFEF00D, 1'b0);
    ld("lw_ffc", 3'b010, 32'h00000FFC, 32'hCAFEF00D, 1'b0);

    // back-pressure
    txn("hold", 1'b1, 1'b0, 3'b010, 32'h10, 32'b0, 5, d, e);
    chk("hold.rdata", d, 32'h123480EF);
    ld("lw_after_hold", 3'b010, 32'h10, 32'h123480EF, 1'b0);

    // reset during ACCESS of a store
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h55AA55AA;
    @(negedge clk);
    clr_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= resp_valid;
      @(negedge clk);
    end
    chk("abort_acc.no_resp", {31'b0, seen}, 32'b0);
    chk("abort_acc.ready", {31'b0, req_ready}, 32'd1);
    ld("lw_20", 3'b010, 32'h20, 32'h00000000, 1'b0);

    // reset during RESP clears outputs and, with INIT_ZERO, the array
    st("sw_30", 3'b010, 32'h30, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h30;
    @(negedge clk);
    clr_req();
    @(negedge clk);
    chk("abort_resp.pre", rdata, 32'hA5A5A5A5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_resp.rdata", rdata, 32'b0);
    chk("abort_resp.hs", {30'b0, req_ready, resp_valid}, 32'b10);
    ld("lw_30_zero", 3'b010, 32'h30, 32'h00000000, 1'b0);
    ld("lw_10_zero", 3'b010, 32'h10, 32'h00000000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
